// File: rtl/tree_mac_accumulator_if.sv
// Bus bundle for tree_mac_accumulator.
// Beat side (driven by the tree MAC core):
//   sum_in, addr_i_in, addr_k_in, val_in
// Result side (FIFO head toward the consumer):
//   result_data, result_addr_i, result_val, result_rdy
// Status (toward the issue scheduler):
//   almost_full, overflow_err
// slave modport  : the accumulator's view.
// master modport : the core/consumer/scheduler view.
interface tree_mac_accumulator_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int ACC_WIDTH       = 24,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8
);
  logic [DATA_WIDTH-1:0]      sum_in;
  logic [ADDRESS_WIDTH_I-1:0] addr_i_in;
  logic [ADDRESS_WIDTH_K-1:0] addr_k_in;
  logic                       val_in;
  logic [ACC_WIDTH-1:0]       result_data;
  logic [ADDRESS_WIDTH_I-1:0] result_addr_i;
  logic                       result_val;
  logic                       result_rdy;
  logic                       almost_full;
  logic                       overflow_err;

  modport master (
    output sum_in, addr_i_in, addr_k_in, val_in, result_rdy,
    input  result_data, result_addr_i, result_val, almost_full, overflow_err
  );

  modport slave (
    input  sum_in, addr_i_in, addr_k_in, val_in, result_rdy,
    output result_data, result_addr_i, result_val, almost_full, overflow_err
  );
endinterface

// File: rtl/tree_mac_accumulator.sv
// tree_mac_accumulator
// Accumulates per-tile dot-product sums from the tree MAC core across
// K_TILES tiles for each row tag. It pushes each finished row sum into an
// output FIFO with a valid/ready handshake. The core cannot stall, so input
// is never back-pressured. Instead, a registered almost_full credit tells
// the scheduler to stop issuing beats.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-low reset
//            (clears the FIFO and status, not the accumulator bank)
//   bus    : tree_mac_accumulator_if.slave
//     sum_in / addr_i_in / addr_k_in / val_in         : beat from core
//     result_data / result_addr_i / result_val / result_rdy : FIFO head
//     almost_full  : free FIFO entries <= CREDIT_MARGIN
//     overflow_err : sticky, set when a final result is lost
//
// Optional feature macro: TREE_MAC_ACC_SATURATE_EN
//   defined   : accumulation saturates at 2^ACC_WIDTH-1, and a saturated
//               final result sets overflow_err
//   undefined : accumulation wraps modulo 2^ACC_WIDTH
module tree_mac_accumulator #(
  parameter int DATA_WIDTH      = 8,
  parameter int ACC_WIDTH       = 24,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int K_TILES         = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int CREDIT_MARGIN   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  tree_mac_accumulator_if.slave bus
);

  localparam int ROWS  = 1 << ADDRESS_WIDTH_I;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH_K:0] K_TILES_W = (ADDRESS_WIDTH_K+1)'(K_TILES);
  localparam logic [ADDRESS_WIDTH_K:0] K_LAST_W  = K_TILES_W - (ADDRESS_WIDTH_K+1)'(1);
  localparam logic [PTR_W:0]           DEPTH_W   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]           MARGIN_W  = (PTR_W+1)'(CREDIT_MARGIN);

`ifdef TREE_MAC_ACC_SATURATE_EN
  // Returns {saturated, value}
  function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[ACC_WIDTH]) return {1'b1, {ACC_WIDTH{1'b1}}};
    return s;
  endfunction
`else
  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
    return a + b;
  endfunction
`endif

  // Accumulator bank and FIFO storage (data only, never reset)
  logic [ACC_WIDTH-1:0]       acc_mem   [ROWS];
  logic [ACC_WIDTH-1:0]       fifo_data [FIFO_DEPTH];
  logic [ADDRESS_WIDTH_I-1:0] fifo_addr [FIFO_DEPTH];
`ifdef TREE_MAC_ACC_SATURATE_EN
  // Remembers whether any tile of the row in progress saturated
  logic                       sat_mem   [ROWS];
  logic [ACC_WIDTH:0]         add_p0;
  logic                       sat_p0;
`endif

  // FIFO control state
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             almost_full_p1, overflow_p1;

  logic                 vld_p0, first_p0, final_p0;
  logic [ACC_WIDTH-1:0] ext_p0, new_p0;
  logic                 head_vld, full, push_req, push_ok, pop, drop;

  // ---- stage p0: beat decode and read-modify-write of the row accumulator ----
  always_comb begin
    vld_p0   = bus.val_in && ({1'b0, bus.addr_k_in} < K_TILES_W);
    first_p0 = (bus.addr_k_in == '0);
    final_p0 = ({1'b0, bus.addr_k_in} == K_LAST_W);
    ext_p0   = ACC_WIDTH'(bus.sum_in);
`ifdef TREE_MAC_ACC_SATURATE_EN
    add_p0   = acc_add(acc_mem[bus.addr_i_in], ext_p0);
    new_p0   = first_p0 ? ext_p0 : add_p0[ACC_WIDTH-1:0];
    sat_p0   = first_p0 ? 1'b0 : (sat_mem[bus.addr_i_in] | add_p0[ACC_WIDTH]);
`else
    new_p0   = first_p0 ? ext_p0 : acc_add(acc_mem[bus.addr_i_in], ext_p0);
`endif
  end

  // The pop is judged on pre-edge occupancy.
  // A full FIFO still takes a push when the head leaves on the same edge.
  always_comb begin
    head_vld  = (count != '0);
    full      = (count == DEPTH_W);
    pop       = head_vld && bus.result_rdy;
    push_req  = vld_p0 && final_p0;
    push_ok   = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    count_nxt = count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      acc_mem[bus.addr_i_in] <= new_p0;
`ifdef TREE_MAC_ACC_SATURATE_EN
      sat_mem[bus.addr_i_in] <= sat_p0;
`endif
    end
    if (push_ok) begin
      fifo_data[wr_ptr] <= new_p0;
      fifo_addr[wr_ptr] <= bus.addr_i_in;
    end
  end

  // ---- stage p1: FIFO pointers, occupancy and registered status ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      almost_full_p1 <= 1'b0;
      overflow_p1    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count          <= count_nxt;
      almost_full_p1 <= ((DEPTH_W - count_nxt) <= MARGIN_W);
`ifdef TREE_MAC_ACC_SATURATE_EN
      overflow_p1    <= overflow_p1 | drop | (push_req & sat_p0);
`else
      overflow_p1    <= overflow_p1 | drop;
`endif
    end
  end

  // Gating on occupancy keeps the head at zero while the FIFO is empty.
  // This holds even though the storage itself is never cleared.
  assign bus.result_val    = head_vld;
  assign bus.result_data   = head_vld ? fifo_data[rd_ptr] : '0;
  assign bus.result_addr_i = head_vld ? fifo_addr[rd_ptr] : '0;
  assign bus.almost_full   = almost_full_p1;
  assign bus.overflow_err  = overflow_p1;

endmodule

// File: tb/tb_tree_mac_accumulator.sv
// Testbench for tree_mac_accumulator.
// A queue-based reference model tracks per-row sums and the output FIFO.
// Directed scenarios and a randomized phase are checked each cycle.
// A second narrow instance covers the wrap/saturate case.
module tb_tree_mac_accumulator;
  localparam int  DW = 8, AW = 24, AIW = 8, AKW = 8, KT = 4, FD = 16, CM = 8;
  localparam longint ACC_MAX = (64'd1 << AW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tree_mac_accumulator_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW),
                            .ADDRESS_WIDTH_I(AIW), .ADDRESS_WIDTH_K(AKW)) bus_if ();
  tree_mac_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDRESS_WIDTH_I(AIW),
                         .ADDRESS_WIDTH_K(AKW), .K_TILES(KT), .FIFO_DEPTH(FD),
                         .CREDIT_MARGIN(CM)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  tree_mac_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(8),
                            .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8)) w_if ();
  tree_mac_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(8), .ADDRESS_WIDTH_I(8),
                         .ADDRESS_WIDTH_K(8), .K_TILES(2), .FIFO_DEPTH(4),
                         .CREDIT_MARGIN(2)) dut_w (.clk(clk), .reset(reset), .bus(w_if));

  typedef struct {
    longint data;
    int     addr;
  } res_t;

  longint acc_m [256];
  bit     sat_m [256];
  res_t   q [$];
  bit     ovf_m;
  int     checks = 0;
  int     errors = 0;
  int     next_k [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    longint hd;
    int     ha;
    hd = (q.size() != 0) ? q[0].data : 64'd0;
    ha = (q.size() != 0) ? q[0].addr : 0;
    check({tag, "_val"},  64'(bus_if.result_val),    64'(q.size() != 0));
    check({tag, "_data"}, 64'(bus_if.result_data),   64'(hd));
    check({tag, "_addr"}, 64'(bus_if.result_addr_i), 64'(ha));
    check({tag, "_af"},   64'(bus_if.almost_full),   64'((FD - q.size()) <= CM));
    check({tag, "_ovf"},  64'(bus_if.overflow_err),  64'(ovf_m));
  endtask

  // One clock of main-DUT stimulus with the matching reference-model update.
  task automatic step(input bit v, input int s, input int r, input int k,
                      input bit rdy, input string tag);
    bit     pop;
    bit     ns;
    longint nv;
    res_t   e;
    bus_if.val_in     = v;
    bus_if.sum_in     = DW'(s);
    bus_if.addr_i_in  = AIW'(r);
    bus_if.addr_k_in  = AKW'(k);
    bus_if.result_rdy = rdy;
    @(posedge clk);
    pop = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (v && k < KT) begin
      if (k == 0) begin
        nv = longint'(s);
        ns = 1'b0;
      end else begin
        nv = acc_m[r] + longint'(s);
        ns = sat_m[r];
      end
`ifdef TREE_MAC_ACC_SATURATE_EN
      if (nv > ACC_MAX) begin
        nv = ACC_MAX;
        ns = 1'b1;
      end
`else
      nv = nv % (ACC_MAX + 1);
`endif
      acc_m[r] = nv;
      sat_m[r] = ns;
      if (k == KT - 1) begin
        e.data = nv;
        e.addr = r;
        if (q.size() < FD) q.push_back(e);
        else ovf_m = 1'b1;
        if (ns) ovf_m = 1'b1;
      end
    end
    #1;
    compare(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    bus_if.val_in = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    #1;
    compare(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    longint wexp;
    bit     wovf;
    int     r, mode;
    reset = 1'b0;
    bus_if.val_in = 1'b0; bus_if.sum_in = '0; bus_if.addr_i_in = '0;
    bus_if.addr_k_in = '0; bus_if.result_rdy = 1'b0;
    w_if.val_in = 1'b0; w_if.sum_in = '0; w_if.addr_i_in = '0;
    w_if.addr_k_in = '0; w_if.result_rdy = 1'b0;
    ovf_m = 1'b0;
    foreach (next_k[i]) next_k[i] = 0;
    #2;
    compare("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Narrow instance: 200 + 100 in 8 bits
`ifdef TREE_MAC_ACC_SATURATE_EN
    wexp = 255; wovf = 1'b1;
`else
    wexp = (200 + 100) % 256; wovf = 1'b0;
`endif
    w_if.result_rdy = 1'b1;
    w_if.val_in = 1'b1; w_if.addr_i_in = 8'd5; w_if.addr_k_in = 8'd0; w_if.sum_in = 8'd200;
    @(posedge clk); #1;
    w_if.addr_k_in = 8'd1; w_if.sum_in = 8'd100;
    @(posedge clk); #1;
    w_if.val_in = 1'b0;
    check("wrap_val",  64'(w_if.result_val),    64'd1);
    check("wrap_data", 64'(w_if.result_data),   64'(wexp));
    check("wrap_addr", 64'(w_if.result_addr_i), 64'd5);
    check("wrap_ovf",  64'(w_if.overflow_err),  64'(wovf));

    // Single row: 10+20+30+40 on row 3
    step(1, 10, 3, 0, 1, "t1k0");
    step(1, 20, 3, 1, 1, "t1k1");
    step(1, 30, 3, 2, 1, "t1k2");
    step(1, 40, 3, 3, 1, "t1k3");
    check("t1_data", 64'(bus_if.result_data),   64'd100);
    check("t1_addr", 64'(bus_if.result_addr_i), 64'd3);
    step(0, 0, 0, 0, 1, "t1pop");

    // Interleaved rows 1 and 2
    for (int j = 0; j < 3; j++) begin
      step(1, 5, 1, j, 1, "il_r1");
      step(1, j + 1, 2, j, 1, "il_r2");
    end
    step(1, 5, 1, 3, 1, "il_r1f");
    check("il_r1_data", 64'(bus_if.result_data),   64'd20);
    check("il_r1_addr", 64'(bus_if.result_addr_i), 64'd1);
    step(1, 4, 2, 3, 1, "il_r2f");
    check("il_r2_data", 64'(bus_if.result_data),   64'd10);
    check("il_r2_addr", 64'(bus_if.result_addr_i), 64'd2);
    step(0, 0, 0, 0, 1, "il_pop");

    // Randomized traffic: ordered tiles per row, idle and out-of-range beats
    for (int n = 0; n < 300; n++) begin
      r    = int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 9));
      if (mode == 0)
        step(0, int'($urandom_range(0, 255)), r, 0, $urandom_range(0, 3) != 0, "rnd_idle");
      else if (mode == 1)
        step(1, int'($urandom_range(0, 255)), r, KT + int'($urandom_range(0, 251)),
             $urandom_range(0, 3) != 0, "rnd_bad_k");
      else begin
        step(1, int'($urandom_range(0, 255)), r, next_k[r], $urandom_range(0, 3) != 0, "rnd");
        next_k[r] = (next_k[r] + 1) % KT;
      end
    end
    repeat (20) step(0, 0, 0, 0, 1, "rnd_drain");

    // Reset in the middle of row 0, with a stored result present
    for (int j = 0; j < KT; j++) step(1, 1, 4, j, 0, "mr_r4");
    step(1, 7, 0, 0, 0, "mr_k0");
    step(1, 9, 0, 1, 0, "mr_k1");
    async_reset("mr_arst");
    check("mr_arst_val", 64'(bus_if.result_val), 64'd0);
    for (int j = 0; j < KT; j++) step(1, j + 1, 0, j, 1, "mr_fresh");
    check("mr_fresh_data", 64'(bus_if.result_data), 64'd10);
    step(0, 0, 0, 0, 1, "mr_pop");

    // Fill with result_rdy low: 17 finals, the last one dropped
    for (int i = 0; i < 17; i++) begin
      step(1, i, i, 0, 0, "fill");
      for (int j = 1; j < KT; j++) step(1, 1, i, j, 0, "fill");
      if (i == 6) check("fill_af7", 64'(bus_if.almost_full), 64'd0);
      if (i == 7) check("fill_af8", 64'(bus_if.almost_full), 64'd1);
    end
    check("fill_ovf", 64'(bus_if.overflow_err), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 64'(bus_if.result_data),   64'(i + 3));
      check("drain_addr", 64'(bus_if.result_addr_i), 64'(i));
      step(0, 0, 0, 0, 1, "drain");
    end
    check("drain_empty", 64'(bus_if.result_val), 64'd0);

    // Full FIFO: pop and push on the same edge
    async_reset("pp_rst");
    for (int i = 0; i < 16; i++) begin
      step(1, i, i, 0, 0, "pp_fill");
      for (int j = 1; j < KT; j++) step(1, 1, i, j, 0, "pp_fill");
    end
    step(1, 50, 20, 0, 0, "pp_r20");
    step(1, 1, 20, 1, 0, "pp_r20");
    step(1, 1, 20, 2, 0, "pp_r20");
    step(1, 1, 20, 3, 1, "pp_both");
    check("pp_af",   64'(bus_if.almost_full),  64'd1);
    check("pp_ovf",  64'(bus_if.overflow_err), 64'd0);
    check("pp_head", 64'(bus_if.result_data),  64'd4);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        check("pp_last_data", 64'(bus_if.result_data),   64'd53);
        check("pp_last_addr", 64'(bus_if.result_addr_i), 64'd20);
      end
      step(0, 0, 0, 0, 1, "pp_drain");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tree_mac_accumulator.md
# tree_mac_accumulator

Downstream stage of the tree MAC core. Consumes the per-tile dot-product `sum_out` together with its `addr_i_out`/`addr_k_out`/`val_out` tags and accumulates partial sums across K tiles per output row index. Completed results go into an output FIFO with a valid/ready handshake. The core pipeline cannot stall, so the block never back-pressures its input; instead it exports an `almost_full` credit signal to the issue scheduler.

## Interface
- DATA_WIDTH, 8, width of `sum_in` (matches core DATA_WIDTH)
- ACC_WIDTH, 24, accumulator and result width; must be ≥ DATA_WIDTH
- ADDRESS_WIDTH_I, 8, row tag width; accumulator bank depth = 2^ADDRESS_WIDTH_I
- ADDRESS_WIDTH_K, 8, tile tag width
- K_TILES, 4, tiles per result; valid range 1..2^ADDRESS_WIDTH_K
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥ 2
- CREDIT_MARGIN, 8, free-entry threshold for `almost_full`

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- sum_in  in  DATA_WIDTH  tile partial sum from core
- addr_i_in  in  ADDRESS_WIDTH_I  row tag
- addr_k_in  in  ADDRESS_WIDTH_K  tile tag
- val_in  in  1  input valid; no ready; sampled every cycle
- result_data  out  ACC_WIDTH  FIFO head: final sum
- result_addr_i  out  ADDRESS_WIDTH_I  FIFO head: row tag
- result_val  out  1  FIFO non-empty
- result_rdy  in  1  consumer accepts head
- almost_full  out  1  FIFO free entries ≤ CREDIT_MARGIN
- overflow_err  out  1  sticky: a final result was dropped

## Operation
- Accepted beat: `val_in`=1 at a rising edge.
- Extend `sum_in` with zeros to ACC_WIDTH to form `ext`.
- If `addr_k_in`==0: `new = ext`. Otherwise `new = acc[addr_i_in] + ext`, computed mod 2^ACC_WIDTH.
- Write `new` to `acc[addr_i_in]`.
- If `addr_k_in`==K_TILES-1: the beat is final. Push {`new`, `addr_i_in`} to the FIFO; write-through, so the same-cycle sum is pushed.
- K_TILES=1: every beat is both first and final, so `result_data` = `ext`.
- `addr_k_in` ≥ K_TILES: the beat is ignored (no write, no push).
- Tiles for one row must arrive in increasing K order. Interleaving different rows is allowed.
- Back-to-back beats to the same row: the second beat sees the first beat's update.
- FIFO pop: `result_val` && `result_rdy` at an edge.
- Push while full:
  - With a simultaneous pop: both the push and the pop succeed.
  - Without a pop: the result is dropped and `overflow_err` is set. It stays set until reset.
- Push while empty: the entry becomes visible on the next cycle. No same-cycle bypass to output.
- `acc` is not reset. Each row is re-initialised by its `addr_k_in`==0 beat.

## Timing
- Latency: a final beat sampled at edge t appears at the FIFO head after edge t, provided the FIFO was empty.
- Throughput: one input beat per cycle, sustained. One pop per cycle.
- `result_data`, `result_addr_i` and `result_val` come from FIFO state registers (no combinational path from `sum_in`).
- `almost_full` is registered from the FIFO count. Scheduler contract: stop issuing while it is high. CREDIT_MARGIN ≥ core pipeline depth + 1 guarantees no overflow.
- Reset assert (async, any cycle, including mid-accumulation):
  - FIFO empty; `result_val`=0; `almost_full`=0 (valid because CREDIT_MARGIN < FIFO_DEPTH); `overflow_err`=0.
  - `result_data` and `result_addr_i` = 0.
  - In-flight partial sums are abandoned.
- Reset deassert: the first beat is accepted at the following edge.

## Configuration
- `TREE_MAC_ACC_SATURATE_EN` defined: accumulation saturates at 2^ACC_WIDTH-1 instead of wrapping. A saturated final result also sets sticky `overflow_err`.
- Undefined: modular wrap. `overflow_err` reports FIFO drops only.

## Test plan
- K_TILES=4, row 3, sums 10,20,30,40 on k=0..3 with `result_rdy`=1 -> one result: `result_data`=100, `result_addr_i`=3, one cycle after the k=3 beat.
- Interleave row 1 (5,5,5,5) and row 2 (1,2,3,4) beat by beat -> results 20 for row 1, then 10 for row 2, in completion order.
- Hold `result_rdy`=0, FIFO_DEPTH=16, CREDIT_MARGIN=8, push 17 finals -> `almost_full` high after 8 pushes; 17th result dropped; `overflow_err`=1; the 16 stored results drain intact.
- FIFO full with `result_rdy`=1 and a final beat on the same edge -> count unchanged, `overflow_err`=0.
- ACC_WIDTH=8, sums 200,100 on k=0..1 (K_TILES=2) -> 44 without the macro; 255 plus `overflow_err`=1 with `TREE_MAC_ACC_SATURATE_EN`.
- Assert `reset` low between the k=1 and k=2 beats of row 0 -> outputs clear immediately; a fresh k=0..3 sequence yields the correct sum with no stale contribution.
